i2s_frame_tx: RTL and testbench

- Parametrised stereo audio frame serializer for the speaker/DAC path. It generates the LR clock, the serial data line and a once-per-frame load strobe from parallel left/right samples.
- It is the generalised form of the fixed 32-bit rotating load-strobe register. Slot width, sample width and the left-justified vs I2S one-bit-delay format are configurable.
- It adds a sample handshake with underrun detection.
- It sits between the sample source (tone/audio generator) and the DAC pins, clocked by the serial bit clock s_clk.

---
 rtl/i2s_frame_tx_if.sv | 27 ++
 rtl/i2s_frame_tx.sv | 152 +++++++++++++++
 tb/tb_i2s_frame_tx.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_tx_if.sv
// Sample-side and DAC-side signal bundle for the stereo frame serializer.
// The slave modport is the serializer; master is the sample source / pin observer.
interface i2s_frame_tx_if #(
  parameter int DATA_W = 16
) ();
  logic              enable;
  logic [DATA_W-1:0] left_in;
  logic [DATA_W-1:0] right_in;
  logic              sample_valid;
  logic              clr_underrun;
  logic              sample_ack;
  logic              lrck;
  logic              sdata;
  logic              load;
  logic              busy;
  logic              underrun;

  modport master (
    output enable, left_in, right_in, sample_valid, clr_underrun,
    input  sample_ack, lrck, sdata, load, busy, underrun
  );

  modport slave (
    input  enable, left_in, right_in, sample_valid, clr_underrun,
    output sample_ack, lrck, sdata, load, busy, underrun
  );
endinterface

// File: rtl/i2s_frame_tx.sv
// Stereo frame serializer: LRCK, MSB-first serial data and a last-bit load strobe,
// all registered on the falling edge of s_clk so the DAC samples them on the rising edge.
module i2s_frame_tx #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 16,
  parameter int I2S_DELAY = 0
) (
  input  logic          s_clk,
  input  logic          rst_n,
  i2s_frame_tx_if.slave bus
);
  localparam int FRAME = 2 * SLOT_W;
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DLY_CNT  = CNT_W'(I2S_DELAY);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(I2S_DELAY + DATA_W);

  if (DATA_W < 1 || SLOT_W < 2 || I2S_DELAY < 0 || I2S_DELAY > 1 ||
      DATA_W + I2S_DELAY > SLOT_W) begin : g_bad_params
    $error("i2s_frame_tx: illegal DATA_W/SLOT_W/I2S_DELAY combination");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] shadow_l_r;
  logic [DATA_W-1:0] shadow_r_r;
  logic              sample_ack_r;
  logic              lrck_r;
  logic              sdata_r;
  logic              load_r;
  logic              busy_r;
  logic              underrun_r;

  logic              start_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [DATA_W-1:0] next_l_s;
  logic [DATA_W-1:0] next_r_s;

  // Serial bit for frame position cnt: delay bit and post-LSB padding are zero.
  function automatic logic slot_bit(input logic [CNT_W-1:0] cnt,
                                    input logic [DATA_W-1:0] l,
                                    input logic [DATA_W-1:0] r);
    logic [CNT_W-1:0]  p;
    logic [DATA_W-1:0] ch;
    logic [DATA_W-1:0] sh;
    logic              b;
    if (cnt >= SLOT_CNT) begin
      p  = cnt - SLOT_CNT;
      ch = r;
    end else begin
      p  = cnt;
      ch = l;
    end
    if (p >= DLY_CNT && p < END_CNT) begin
      sh = ch << (p - DLY_CNT);
      b  = sh[DATA_W-1];
    end else begin
      sh = '0;
      b  = 1'b0;
    end
    return b;
  endfunction

  // Frame-start decision and the sample values the new frame will carry.
  always_comb begin
    start_s   = bus.enable && (state_r == IDLE || cnt_r == LAST_CNT);
    cnt_inc_s = cnt_r + CNT_W'(1);
    next_l_s  = shadow_l_r;
    next_r_s  = shadow_r_r;
    if (start_s && bus.sample_valid) begin
      next_l_s = bus.left_in;
      next_r_s = bus.right_in;
    end else begin
      next_l_s = shadow_l_r;
      next_r_s = shadow_r_r;
    end
  end

  // Frame FSM with registered pin outputs; enable only matters at a frame boundary.
  always_ff @(negedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      shadow_l_r   <= '0;
      shadow_r_r   <= '0;
      sample_ack_r <= 1'b0;
      lrck_r       <= 1'b0;
      sdata_r      <= 1'b0;
      load_r       <= 1'b0;
      busy_r       <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      sample_ack_r <= start_s && bus.sample_valid;
      // A set on the same edge as a clear must win.
      if (start_s && !bus.sample_valid) begin
        underrun_r <= 1'b1;
      end else if (bus.clr_underrun) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end

      if (start_s) begin
        state_r    <= RUN;
        cnt_r      <= '0;
        shadow_l_r <= next_l_s;
        shadow_r_r <= next_r_s;
        busy_r     <= 1'b1;
        lrck_r     <= 1'b0;
        sdata_r    <= slot_bit('0, next_l_s, next_r_s);
        load_r     <= 1'b0;
      end else begin
        case (state_r)
          RUN: begin
            if (cnt_r == LAST_CNT) begin
              state_r <= IDLE;
              cnt_r   <= '0;
              busy_r  <= 1'b0;
              lrck_r  <= 1'b0;
              sdata_r <= 1'b0;
              load_r  <= 1'b0;
            end else begin
              cnt_r   <= cnt_inc_s;
              busy_r  <= 1'b1;
              lrck_r  <= (cnt_inc_s >= SLOT_CNT);
              sdata_r <= slot_bit(cnt_inc_s, shadow_l_r, shadow_r_r);
              load_r  <= (cnt_inc_s == LAST_CNT);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            lrck_r  <= 1'b0;
            sdata_r <= 1'b0;
            load_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sample_ack = sample_ack_r;
  assign bus.lrck       = lrck_r;
  assign bus.sdata      = sdata_r;
  assign bus.load       = load_r;
  assign bus.busy       = busy_r;
  assign bus.underrun   = underrun_r;
endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: a left-justified and an I2S-format instance checked every
// cycle against a frame-level reference model, plus directed pattern checks.
module tb_i2s_frame_tx;
  logic s_clk = 1'b1;
  logic rst_n = 1'b0;
  always #5 s_clk = ~s_clk;

  i2s_frame_tx_if #(.DATA_W(16)) bus_a ();
  i2s_frame_tx_if #(.DATA_W(24)) bus_b ();

  i2s_frame_tx dut_a (.s_clk(s_clk), .rst_n(rst_n), .bus(bus_a));
  i2s_frame_tx #(.DATA_W(24), .SLOT_W(32), .I2S_DELAY(1))
    dut_b (.s_clk(s_clk), .rst_n(rst_n), .bus(bus_b));

  logic        en [2];
  logic        vld[2];
  logic        clr[2];
  logic [31:0] lin[2];
  logic [31:0] rin[2];

  assign bus_a.enable       = en[0];
  assign bus_a.sample_valid = vld[0];
  assign bus_a.clr_underrun = clr[0];
  assign bus_a.left_in      = lin[0][15:0];
  assign bus_a.right_in     = rin[0][15:0];
  assign bus_b.enable       = en[1];
  assign bus_b.sample_valid = vld[1];
  assign bus_b.clr_underrun = clr[1];
  assign bus_b.left_in      = lin[1][23:0];
  assign bus_b.right_in     = rin[1][23:0];

  // {sample_ack, lrck, sdata, load, busy, underrun}
  logic [5:0] obs_a, obs_b;
  assign obs_a = {bus_a.sample_ack, bus_a.lrck, bus_a.sdata, bus_a.load, bus_a.busy, bus_a.underrun};
  assign obs_b = {bus_b.sample_ack, bus_b.lrck, bus_b.sdata, bus_b.load, bus_b.busy, bus_b.underrun};

  int dw[2] = '{16, 24};
  int sw[2] = '{16, 32};
  int dl[2] = '{0, 1};

  // Reference model: whether a frame is running, position in it, and its expected bit image.
  bit          m_run[2];
  int          m_cnt[2];
  logic [31:0] m_l[2];
  logic [31:0] m_r[2];
  bit          m_und[2];
  bit          m_ack[2];
  logic [63:0] m_frame[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int k);
    return (32'd1 << dw[k]) - 32'd1;
  endfunction

  // Whole frame as a bit vector, first transmitted bit at the top: each slot is
  // delay zeros, then the sample, then zero padding.
  function automatic logic [63:0] frame_of(input int k, input logic [31:0] l, input logic [31:0] r);
    logic [63:0] sl, sr;
    sl = 64'(l & mask_of(k)) << (sw[k] - dw[k] - dl[k]);
    sr = 64'(r & mask_of(k)) << (sw[k] - dw[k] - dl[k]);
    return (sl << sw[k]) | sr;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_cnt[k] = 0; m_l[k] = 32'd0; m_r[k] = 32'd0;
      m_und[k] = 1'b0; m_ack[k] = 1'b0; m_frame[k] = 64'd0;
    end
  endtask

  task automatic model_step(input int k);
    int frame;
    bit start;
    frame = 2 * sw[k];
    start = en[k] && (!m_run[k] || m_cnt[k] == frame - 1);
    if (start && !vld[k]) m_und[k] = 1'b1;
    else if (clr[k]) m_und[k] = 1'b0;
    m_ack[k] = 1'b0;
    if (start) begin
      if (vld[k]) begin
        m_l[k] = lin[k] & mask_of(k);
        m_r[k] = rin[k] & mask_of(k);
        m_ack[k] = 1'b1;
      end
      m_run[k] = 1'b1;
      m_cnt[k] = 0;
      m_frame[k] = frame_of(k, m_l[k], m_r[k]);
    end else if (m_run[k]) begin
      if (m_cnt[k] == frame - 1) begin
        m_run[k] = 1'b0;
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic [5:0] o;
    int frame;
    string p;
    frame = 2 * sw[k];
    o = (k == 0) ? obs_a : obs_b;
    p = (k == 0) ? "a" : "b";
    check_eq({p, ".sample_ack"}, 64'(o[5]), 64'(m_ack[k]));
    check_eq({p, ".lrck"},  64'(o[4]), 64'(m_run[k] && m_cnt[k] >= sw[k]));
    check_eq({p, ".sdata"}, 64'(o[3]), 64'(m_run[k] ? m_frame[k][frame - 1 - m_cnt[k]] : 1'b0));
    check_eq({p, ".load"},  64'(o[2]), 64'(m_run[k] && m_cnt[k] == frame - 1));
    check_eq({p, ".busy"},  64'(o[1]), 64'(m_run[k]));
    check_eq({p, ".underrun"}, 64'(o[0]), 64'(m_und[k]));
  endtask

  // One active (falling) edge, then check both instances on the following rising edge.
  task automatic cycle();
    @(negedge s_clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(posedge s_clk);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [63:0] cap, cap_lr, exp_v;
  logic [31:0] l1, r1;
  int          n_ack, n_load;

  initial begin
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; vld[k] = 1'b0; clr[k] = 1'b0; lin[k] = 32'd0; rin[k] = 32'd0;
    end
    model_reset();
    #3;
    check_eq("reset_outputs_a", 64'(obs_a), 64'd0);
    check_eq("reset_outputs_b", 64'(obs_b), 64'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);

    // Left-justified directed frame.
    lin[0] = 32'hA5C3; rin[0] = 32'h8001; vld[0] = 1'b1; en[0] = 1'b1;
    cap = 64'd0; cap_lr = 64'd0; n_ack = 0; n_load = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (i == 0) begin en[0] = 1'b0; vld[0] = 1'b0; end
      cap    = {cap[62:0], bus_a.sdata};
      cap_lr = {cap_lr[62:0], bus_a.lrck};
      if (bus_a.sample_ack) n_ack++;
      if (bus_a.load) n_load++;
      if (i == 0)  check_eq("lj_ack_bit0", 64'(bus_a.sample_ack), 64'd1);
      if (i == 31) check_eq("lj_load_bit31", 64'(bus_a.load), 64'd1);
    end
    check_eq("lj_sdata", cap, 64'hA5C38001);
    check_eq("lj_lrck", cap_lr, 64'h0000FFFF);
    check_eq("lj_ack_count", 64'(n_ack), 64'd1);
    check_eq("lj_load_count", 64'(n_load), 64'd1);
    cycle();
    check_eq("lj_idle_after", 64'(bus_a.busy), 64'd0);

    // I2S-format directed frame on the second instance.
    lin[1] = 32'h800001; rin[1] = 32'h7FFFFE; vld[1] = 1'b1; en[1] = 1'b1;
    cap = 64'd0; n_load = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (i == 0) begin en[1] = 1'b0; vld[1] = 1'b0; end
      cap = {cap[62:0], bus_b.sdata};
      if (bus_b.load) n_load++;
      if (i == 63) check_eq("i2s_load_bit63", 64'(bus_b.load), 64'd1);
    end
    check_eq("i2s_sdata", cap, 64'h40000080_3FFFFF00);
    check_eq("i2s_load_count", 64'(n_load), 64'd1);
    cycle();
    check_eq("i2s_idle_after", 64'(bus_b.busy), 64'd0);

    // Back-to-back frames with an underrun at the second frame start.
    l1 = 32'($urandom) & 32'hFFFF; r1 = 32'($urandom) & 32'hFFFF;
    lin[0] = l1; rin[0] = r1; vld[0] = 1'b1; en[0] = 1'b1;
    cycle();
    lin[0] = 32'($urandom); rin[0] = 32'($urandom);
    cycles(31);
    vld[0] = 1'b0;
    cap = 64'd0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (i == 0) begin
        check_eq("b2b_no_gap", 64'(bus_a.busy), 64'd1);
        check_eq("b2b_underrun_rise", 64'(bus_a.underrun), 64'd1);
        check_eq("b2b_no_ack", 64'(bus_a.sample_ack), 64'd0);
      end
      cap = {cap[62:0], bus_a.sdata};
    end
    exp_v = {32'd0, l1[15:0], r1[15:0]};
    check_eq("b2b_repeat_data", cap, exp_v);
    vld[0] = 1'b1; lin[0] = 32'($urandom); rin[0] = 32'($urandom);
    cycle();
    check_eq("b2b_frame3_ack", 64'(bus_a.sample_ack), 64'd1);
    en[0] = 1'b0;
    cycles(31);
    check_eq("b2b_underrun_sticky", 64'(bus_a.underrun), 64'd1);
    cycles(2);

    // Enable toggles mid-frame; only the boundary value matters.
    en[0] = 1'b1; vld[0] = 1'b1; lin[0] = 32'($urandom); rin[0] = 32'($urandom);
    cycle();
    cycles(5);  en[0] = 1'b0;
    cycles(5);  en[0] = 1'b1;
    cycles(21);
    check_eq("stop_frameN_bit31", 64'(bus_a.load), 64'd1);
    cycle();
    check_eq("stop_frameN1_start", 64'(bus_a.busy), 64'd1);
    cycles(20); en[0] = 1'b0;
    cycles(11);
    check_eq("stop_busy_bit31", 64'(bus_a.busy), 64'd1);
    cycle();
    check_eq("stop_busy_fall", 64'(bus_a.busy), 64'd0);

    // Clear coinciding with a set, then a clear with valid frames.
    en[0] = 1'b1; vld[0] = 1'b0; clr[0] = 1'b1;
    cycle();
    check_eq("clr_vs_set", 64'(bus_a.underrun), 64'd1);
    clr[0] = 1'b0; en[0] = 1'b0;
    cycles(32);
    en[0] = 1'b1; vld[0] = 1'b1; clr[0] = 1'b1;
    cycle();
    check_eq("clr_after_valid", 64'(bus_a.underrun), 64'd0);
    clr[0] = 1'b0; en[0] = 1'b0;
    cycles(32);

    // Randomized traffic on both instances.
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 2; k++) begin
        en[k]  = ($urandom_range(0, 3) != 0);
        vld[k] = ($urandom_range(0, 4) != 0);
        clr[k] = ($urandom_range(0, 7) == 0);
        lin[k] = 32'($urandom);
        rin[k] = 32'($urandom);
      end
      cycle();
    end
    for (int k = 0; k < 2; k++) begin en[k] = 1'b0; clr[k] = 1'b0; end
    cycles(66);

    // Reset during a running frame at bit 7.
    en[0] = 1'b1; vld[0] = 1'b1; lin[0] = 32'($urandom); rin[0] = 32'($urandom);
    cycle();
    cycles(7);
    check_eq("rst_at_bit7_busy", 64'(bus_a.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_midframe_async", 64'(obs_a), 64'd0);
    model_reset();
    cycles(3);
    en[0] = 1'b0; en[1] = 1'b0;
    rst_n = 1'b1;
    cycles(40);
    check_eq("rst_idle_after_40", 64'(obs_a), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
